// File: rtl/acoustics_pkg.sv
// Shared constants, frame word field offsets and FSM state type for the ADC capture path.
// Each channel field sits at CH_LSB[ch]. Channels 3..0 are PF, PA, SF and SA.
package acoustics_pkg;

  localparam int ADC_BITS    = 24;
  localparam int N_CH        = 4;
  localparam int FRAME_W     = 128;
  localparam int SEQ_LSB     = 112;
  localparam int FLAG_MISSED = 97;
  localparam int FLAG_OVF    = 96;
  localparam int CH_LSB [N_CH] = '{0, ADC_BITS, 2*ADC_BITS, 3*ADC_BITS};

  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;

endpackage

// File: rtl/adc_sclk_gen.sv
// Divides clk to sclk (half-period SCLK_DIV cycles) and flags the edge on which sclk will rise or fall.
// Latency: first rise SCLK_DIV cycles after start. There is no backpressure; it free-runs while run is high.
module adc_sclk_gen #(
  parameter int SCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic sclk,
  output logic sclk_rise,
  output logic sclk_fall
);

  localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);

  logic [7:0] div_cnt;
  logic       wrap;

  // Strobes are high during the cycle whose closing edge toggles sclk.
  assign wrap      = run && (div_cnt == DIV_LAST);
  assign sclk_rise = wrap && !sclk;
  assign sclk_fall = wrap && sclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (start) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (run) begin
      if (wrap) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/adc_frame_capture.sv
// Captures 4x24-bit ADC conversions on the drdy_n fall and writes one 128-bit frame word per conversion. ADC_TEST_PATTERN_EN adds a test_mode input.
// Latency: 3 clk cycles from drdy_n to the shift phase. There is no stall: a frame that meets fifo_full is dropped and counted.
module adc_frame_capture
  import acoustics_pkg::*;
#(
  parameter int SCLK_DIV = 2,
  parameter int SEQ_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               drdy_n,
  input  logic [N_CH-1:0]    miso,
  output logic               sclk,
  input  logic               fifo_full,
  output logic               fifo_wr,
  output logic [FRAME_W-1:0] fifo_data,
  output logic               busy,
  output logic [15:0]        drop_count
`ifdef ADC_TEST_PATTERN_EN
  ,
  input  logic               test_mode
`endif
);

  localparam int BCW = $clog2(ADC_BITS);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(ADC_BITS - 1);

  state_t               state, state_nxt;
  logic [2:0]           drdy_sync;
  logic                 drdy_fall;
  logic                 start;
  logic                 sclk_fall;
  logic                 sclk_rise_unused;
  logic [BCW-1:0]       bit_cnt;
  logic [ADC_BITS-1:0]  ch_sr [N_CH];
  logic [SEQ_W-1:0]     seq;
  logic                 missed_flag;
  logic                 ovf_flag;
  logic [FRAME_W-1:0]   frame_word;

  // [1] is the synchronised level, [2] its previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drdy_sync <= 3'b111;
    else        drdy_sync <= {drdy_sync[1:0], drdy_n};
  end

  assign drdy_fall = drdy_sync[2] & ~drdy_sync[1];
  assign busy      = (state != IDLE);

  adc_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .run       (state == SHIFT),
    .sclk      (sclk),
    .sclk_rise (sclk_rise_unused),
    .sclk_fall (sclk_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (drdy_fall && enable) begin
          state_nxt = SHIFT;
          start     = 1'b1;
        end
      end
      SHIFT: begin
        if (sclk_fall && (bit_cnt == BIT_LAST)) state_nxt = WRITE;
      end
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_word = '0;
    frame_word[SEQ_LSB +: 16]  = 16'(seq);
    frame_word[FLAG_MISSED]    = missed_flag;
    frame_word[FLAG_OVF]       = ovf_flag;
    for (int c = 0; c < N_CH; c++) begin
`ifdef ADC_TEST_PATTERN_EN
      if (test_mode) frame_word[CH_LSB[c] +: ADC_BITS] = {2'(c), 16'(seq), 6'b0};
      else           frame_word[CH_LSB[c] +: ADC_BITS] = ch_sr[c];
`else
      frame_word[CH_LSB[c] +: ADC_BITS] = ch_sr[c];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      for (int c = 0; c < N_CH; c++) ch_sr[c] <= '0;
      seq         <= '0;
      missed_flag <= 1'b0;
      ovf_flag    <= 1'b0;
      drop_count  <= '0;
      fifo_wr     <= 1'b0;
      fifo_data   <= '0;
    end else begin
      fifo_wr <= 1'b0;
      if (start) bit_cnt <= '0;
      if (state == SHIFT && sclk_fall) begin
        for (int c = 0; c < N_CH; c++) ch_sr[c] <= {ch_sr[c][ADC_BITS-2:0], miso[c]};
        bit_cnt <= bit_cnt + BCW'(1);
      end
      if (state == WRITE) begin
        if (!fifo_full) begin
          fifo_wr     <= 1'b1;
          fifo_data   <= frame_word;
          seq         <= seq + SEQ_W'(1);
          missed_flag <= 1'b0;
          ovf_flag    <= 1'b0;
        end else begin
          if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
          ovf_flag <= 1'b1;
        end
      end
      // A conversion that lands during a frame outlives the clear in the same cycle.
      if (drdy_fall && state != IDLE) missed_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adc_frame_capture.sv
// Directed bench for adc_frame_capture: a frame-level model predicts each written word and the drop count.
// A compare process checks every write, the hold value of fifo_data and the sclk idle level on each cycle.
module tb_adc_frame_capture;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         drdy_n = 1'b1;
  logic [3:0]   miso = 4'h0;
  logic         fifo_full = 1'b0;
  logic         sclk;
  logic         fifo_wr;
  logic [127:0] fifo_data;
  logic         busy;
  logic [15:0]  drop_count;
`ifdef ADC_TEST_PATTERN_EN
  logic         test_mode = 1'b0;
`endif

  adc_frame_capture dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .drdy_n     (drdy_n),
    .miso       (miso),
    .sclk       (sclk),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_data  (fifo_data),
    .busy       (busy),
    .drop_count (drop_count)
`ifdef ADC_TEST_PATTERN_EN
    ,
    .test_mode  (test_mode)
`endif
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  int           n_writes = 0;
  logic [127:0] last_word = '0;
  logic [127:0] exp_q[$];
  logic [23:0]  pat [4];

  // Frame-level model state
  logic [15:0]  m_seq = '0;
  bit           m_missed = 0;
  bit           m_ovf = 0;
  logic [15:0]  m_drops = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_word(input logic [15:0] s, input bit missed, input bit ovf,
                                           input logic [23:0] pf, pa, sf, sa);
    return {s, 14'd0, missed, ovf, pf, pa, sf, sa};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      last_word = '0;
    end else begin
      if (fifo_wr) begin
        n_writes++;
        if (exp_q.size() == 0) chk("unexpected_wr", 1, 0);
        else                   chk("word", fifo_data, exp_q.pop_front());
        last_word = fifo_data;
      end else begin
        chk("data_hold", fifo_data, last_word);
      end
      if (!busy) chk("sclk_idle", sclk, 0);
    end
  end

  // One conversion. abort_fall>0 pulses rst_n right after that sclk fall.
  task automatic frame(input logic [23:0] p3, p2, p1, p0, input bit full, input bit extra,
                       input bit drop_en, input int abort_fall, input bit tmode);
    int lat, busy_n, rises, falls, first_rise, k, wr0, t;
    logic sclk_q;
    bit aborted;
    logic [23:0] f [4];
    pat[3] = p3; pat[2] = p2; pat[1] = p1; pat[0] = p0;
    wr0 = n_writes;
    if (extra) m_missed = 1;
    for (int c = 0; c < 4; c++) f[c] = tmode ? {c[1:0], m_seq, 6'b0} : pat[c];
    if (abort_fall == 0) begin
      if (full) begin
        m_ovf = 1;
        if (m_drops != 16'hFFFF) m_drops++;
      end else begin
        exp_q.push_back(mk_word(m_seq, m_missed, m_ovf, f[3], f[2], f[1], f[0]));
        m_seq++;
        m_missed = 0;
        m_ovf = 0;
      end
    end
    fifo_full = full;
`ifdef ADC_TEST_PATTERN_EN
    test_mode = tmode;
`endif
    @(negedge clk);
    drdy_n = 1'b0;
    lat = 0;
    while (!busy && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("drdy_latency", lat, 3);
    busy_n = 0; rises = 0; falls = 0; first_rise = 0; k = 0; t = 0;
    sclk_q = 1'b0; aborted = 0;
    while (busy && t < 300) begin
      t++;
      busy_n++;
      if (sclk && !sclk_q) begin
        rises++;
        if (first_rise == 0) first_rise = t;
        if (k < 24) begin
          for (int c = 0; c < 4; c++) miso[c] = pat[c][23-k];
          k++;
        end
      end
      if (!sclk && sclk_q) begin
        falls++;
        if (falls == abort_fall) begin
          rst_n = 1'b0;
          #1;
          chk("abort_sclk", sclk, 0);
          chk("abort_busy", busy, 0);
          aborted = 1;
          break;
        end
      end
      if (t == 3) drdy_n = 1'b1;
      if (extra && t == 40) drdy_n = 1'b0;
      if (extra && t == 45) drdy_n = 1'b1;
      if (drop_en && t == 20) enable = 1'b0;
      sclk_q = sclk;
      @(negedge clk);
    end
    if (aborted) begin
      m_seq = '0; m_missed = 0; m_ovf = 0; m_drops = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drdy_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_no_wr", n_writes - wr0, 0);
      chk("abort_drops", drop_count, 0);
    end else begin
      chk("frame_done", busy, 0);
      // 2*24*2 = 96 shift cycles plus the one-cycle WRITE state
      chk("busy_cycles", busy_n, 97);
      chk("sclk_pulses", rises, 24);
      chk("first_rise", first_rise, 3);
      repeat (2) @(negedge clk);
      chk("write_count", n_writes - wr0, full ? 0 : 1);
      chk("drop_count", drop_count, m_drops);
    end
    fifo_full = 1'b0;
`ifdef ADC_TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
  endtask

  task automatic ignore_check();
    bit seen;
    seen = 0;
    @(negedge clk);
    drdy_n = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    chk("drdy_ignored", seen, 0);
    drdy_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_sclk", sclk, 0);
    chk("rst_fifo_wr", fifo_wr, 0);
    chk("rst_fifo_data", fifo_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop_count", drop_count, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    ignore_check();
    enable = 1'b1;

    frame(24'hA5A5A5, 24'h123456, 24'hFFFFFF, 24'h000001, 0, 0, 0, 0, 0);
    chk("frame0_literal", last_word, 128'h0000_0000_A5A5A5_123456_FFFFFF_000001);
    frame(24'h000000, 24'hFFFFFF, 24'h5A5A5A, 24'h800000, 0, 0, 0, 0, 0);
    chk("seq1", last_word[127:112], 16'd1);
    frame(24'h0F0F0F, 24'hF0F0F0, 24'h000F00, 24'hABCDEF, 0, 0, 0, 0, 0);
    chk("seq2", last_word[127:112], 16'd2);
    chk("no_drops", drop_count, 0);

    frame(24'h111111, 24'h222222, 24'h333333, 24'h444444, 1, 0, 0, 0, 0);
    chk("drop_after_full", drop_count, 1);
    frame(24'h555555, 24'h666666, 24'h777777, 24'h888888, 0, 0, 0, 0, 0);
    chk("ovf_bit", last_word[96], 1);
    chk("ovf_seq", last_word[127:112], 16'd3);
    frame(24'h999999, 24'hAAAAAA, 24'hBBBBBB, 24'hCCCCCC, 0, 1, 0, 0, 0);
    chk("ovf_cleared", last_word[96], 0);
    chk("missed_bit", last_word[97], 1);

    frame(24'hDEADBE, 24'hEF0123, 24'h456789, 24'hFEDCBA, 0, 0, 1, 0, 0);
    chk("missed_cleared", last_word[97], 0);
    chk("en_drop_seq", last_word[127:112], 16'd5);
    ignore_check();
    enable = 1'b1;

    frame(24'h13579B, 24'h2468AC, 24'hFFFF00, 24'h00FFFF, 0, 0, 0, 10, 0);
    frame(24'h800001, 24'h7FFFFE, 24'hC3C3C3, 24'h3C3C3C, 0, 0, 0, 0, 0);
    chk("after_reset", last_word, 128'h0000_0000_800001_7FFFFE_C3C3C3_3C3C3C);

`ifdef ADC_TEST_PATTERN_EN
    for (int i = 0; i < 4; i++)
      frame(24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C, 0, 0, 0, 0, 0);
    frame(24'h000000, 24'h000000, 24'h000000, 24'h000000, 0, 0, 0, 0, 1);
    chk("tp_pf", last_word[95:72], 24'hC00140);
    chk("tp_sa", last_word[23:0], 24'h000140);
`endif

    repeat (3) @(negedge clk);
    chk("pending_words", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
